// File: rtl/mux_tx.sv
// Two-lane transmit multiplexer. Each lane feeds a small FIFO; the output
// byte stream alternates between lane 0 and lane 1 slots every cycle, so the
// receiver can route bytes by slot alone. A slot whose lane FIFO is empty
// carries the idle filler byte with the valid flag low.
module mux_tx #(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IDLE_BYTE  = 8'h7C
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic [DATA_W-1:0] DATA_IN0,
  input  logic              VALID_IN0,
  output logic              READY0,
  input  logic [DATA_W-1:0] DATA_IN1,
  input  logic              VALID_IN1,
  output logic              READY1,
  output logic [DATA_W-1:0] Tx_buffer,
  output logic              VALID_OUT,
  output logic              SLOT_OUT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } slot_t;

  slot_t slot;

  logic [DATA_W-1:0] mem0 [FIFO_DEPTH];
  logic [DATA_W-1:0] mem1 [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
  logic [CNT_W-1:0]  cnt0, cnt1;
  logic              push0, push1, pop0, pop1;

  logic [DATA_W-1:0] tx_byte_p1;
  logic              vld_p1;
  logic              slot_p1;

  // Readiness depends on occupancy only, so a full FIFO refuses a push even
  // in the same cycle its head is popped.
  assign READY0 = (cnt0 < CNT_W'(FIFO_DEPTH));
  assign READY1 = (cnt1 < CNT_W'(FIFO_DEPTH));

  assign push0 = VALID_IN0 & READY0;
  assign push1 = VALID_IN1 & READY1;
  assign pop0  = (slot == LANE0) && (cnt0 != '0);
  assign pop1  = (slot == LANE1) && (cnt1 != '0);

  // Lane storage: write-only on accepted pushes, contents need no reset.
  always_ff @(posedge CLK) begin
    if (push0) mem0[wr_ptr0] <= DATA_IN0;
    if (push1) mem1[wr_ptr1] <= DATA_IN1;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo FIFO_DEPTH.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr0 <= '0;
      rd_ptr0 <= '0;
      cnt0    <= '0;
      wr_ptr1 <= '0;
      rd_ptr1 <= '0;
      cnt1    <= '0;
    end else begin
      if (push0) wr_ptr0 <= wr_ptr0 + PTR_W'(1);
      if (pop0)  rd_ptr0 <= rd_ptr0 + PTR_W'(1);
      cnt0 <= cnt0 + CNT_W'(push0) - CNT_W'(pop0);
      if (push1) wr_ptr1 <= wr_ptr1 + PTR_W'(1);
      if (pop1)  rd_ptr1 <= rd_ptr1 + PTR_W'(1);
      cnt1 <= cnt1 + CNT_W'(push1) - CNT_W'(pop1);
    end
  end

  // Slot machine and output stage: toggle every cycle, emit the current
  // lane's head byte or the idle filler tagged with the current slot.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      slot       <= LANE0;
      tx_byte_p1 <= IDLE_BYTE;
      vld_p1     <= 1'b0;
      slot_p1    <= 1'b0;
    end else begin
      slot    <= (slot == LANE0) ? LANE1 : LANE0;
      slot_p1 <= (slot == LANE1);
      if (pop0) begin
        tx_byte_p1 <= mem0[rd_ptr0];
        vld_p1     <= 1'b1;
      end else if (pop1) begin
        tx_byte_p1 <= mem1[rd_ptr1];
        vld_p1     <= 1'b1;
      end else begin
        tx_byte_p1 <= IDLE_BYTE;
        vld_p1     <= 1'b0;
      end
    end
  end

  assign Tx_buffer = tx_byte_p1;
  assign VALID_OUT = vld_p1;
  assign SLOT_OUT  = slot_p1;

endmodule
